sigma_delta_adc_decim: RTL
==========================

// Module: sigma_delta_adc_decim
// PURPOSE
//  Receive side of the 1-bit sigma-delta path: a 1-bit modulator feeding a decimating filter.
//  An external comparator compares the analog input against an RC-filtered copy of FBout.
//  The block synchronises that comparator bit and drives it back out on FBout to close the loop.
//  A 3rd-order CIC decimator (R=2**RLOG2) turns the bitstream into excess-2**MSBI samples with a valid strobe.
// PARAMETERS
//  MSBI   7     highest bit number of DOUT (DOUT is MSBI+1 bits, excess 2**MSBI).
//  RLOG2  4     log2 of decimation ratio R; must satisfy 3*RLOG2 >= MSBI+1.
//  INV    1'b1  FBout polarity: FBout = loop bit ^ INV.
// PORTS
//  CLK     in   1        clock.
//  RESET   in   1        asynchronous, active-high reset.
//  CE      in   1        modulator sample enable; the loop and CIC advance only on CLK edges with CE=1.
//  ADCin   in   1        comparator output, asynchronous to CLK.
//  FBout   out  1        feedback to the external RC integrator.
//  DOUT    out  MSBI+1   decimated sample, excess 2**MSBI.
//  DVALID  out  1        1-CLK strobe: DOUT updated this cycle.
// BEHAVIOUR
//  Reset values: sync flops=0, FBout=INV, DOUT=2**MSBI (midscale), DVALID=0.
//   Integrators, comb delays, decimation counter and warm-up counter are all 0.
//   Reset asserted mid-operation aborts immediately; no partial sample is emitted.
//  Sync: ADCin passes through a 2-flop synchroniser clocked every CLK (not CE-gated) -> bit b.
//  Loop: when CE=1, FBout <= b ^ INV and b enters the CIC.
//   Latency is 3 CLK from ADCin to FBout when CE is held high.
//  CIC width W = 3*RLOG2+1. Input is unsigned 0/1, zero-extended to W.
//   Integrators I1..I3 update only on CE=1 and wrap modulo 2**W; wrap is intentional.
//  Decimation counter: runs 0..R-1 on CE=1. On the CE cycle where count==R-1:
//   - the counter wraps to 0;
//   - the 3 combs C_k = x - delay_k are evaluated combinationally from I3, using modular W-bit subtraction;
//   - each delay_k <= its comb input.
//  Comb result V lies in 0..R**3. Sample S = V >> (3*RLOG2-MSBI-1), saturated to 2**(MSBI+1)-1.
//   V==R**3 (all-ones input) is the only case that saturates.
//  Output: S is registered into DOUT on the CLK edge after the boundary CE.
//   DVALID=1 for exactly that one cycle.
//  Warm-up: the first 3 boundaries after reset update the comb delays only.
//   DOUT stays midscale and DVALID stays 0. DVALID first rises at the 4th boundary.
//  CE=0: nothing changes except the sync flops. DVALID never asserts on a cycle without a preceding boundary CE.
//  Back-to-back: with CE held high, DVALID pulses exactly once every R CLK.
//  Output is monotonic in ones density. The stated density->DOUT mapping holds for patterns periodic in R.
// STRUCTURE
//  Shared package: CIC_ORDER=3 and function cic_width(rlog2)=3*rlog2+1.
//   Assertion check: 3*RLOG2 >= MSBI+1.
//  Sub-module sd_sync2: 2-flop synchroniser with asynchronous reset.
//  Everything else is flat: integrators, combs, counters, output register.
// TESTING  (MSBI=7, RLOG2=4: R=16, W=13, shift=4)
//  - Reset only, CE=1, ADCin=0 -> FBout=1 (INV=1); DOUT=0x80 and DVALID=0 through the first 3 boundaries.
//  - ADCin=1 constant, CE=1 -> first DVALID 64 CE after reset (+sync latency); DOUT=0xFF (saturated); FBout=0.
//  - ADCin=0 constant -> DOUT=0x00 from the first DVALID onward.
//  - ADCin toggling every CE, 50% density -> DOUT=0x80 steady. 1-in-4 pattern -> DOUT=0x40. 3-in-4 -> DOUT=0xC0.
//  - CE asserted 1 cycle in 3, ADCin=1 -> DVALID period 48 CLK; values identical to the CE=1 case; no DVALID while CE=0.
//  - RESET pulsed mid-frame after steady 0xC0 -> immediately DOUT=0x80, DVALID=0, FBout=INV.
//    Next DVALID only at the 4th boundary after release.
//  - Long run (>2**13 CE) at 1-in-4 density -> DOUT stays 0x40 across integrator wrap.

Source files
------------

// File: rtl/sigma_delta_adc_decim_pkg.sv
// Shared constants and helpers for the sigma-delta receive path.
// Holds the CIC order and the derived accumulator width.
package sigma_delta_adc_decim_pkg;

    localparam int CIC_ORDER = 3;
    localparam int WARMUP_BOUNDARIES = 3;

    typedef enum logic [0:0] {
        PH_WARMUP,
        PH_RUN
    } phase_e;

    function automatic int cic_width(input int rlog2);
        return CIC_ORDER * rlog2 + 1;
    endfunction

endpackage

// File: rtl/sd_sync2.sv
// Two-flop synchroniser for the asynchronous comparator bit.
// Runs on every CLK edge, independent of the modulator enable.
module sd_sync2 (
    input  logic CLK,
    input  logic RESET,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/sigma_delta_adc_decim.sv
// 1-bit sigma-delta loop closure plus 3rd-order CIC decimator.
// Produces excess-2**MSBI samples with a one-cycle valid strobe.
module sigma_delta_adc_decim
    import sigma_delta_adc_decim_pkg::*;
#(
    parameter int   MSBI  = 7,
    parameter int   RLOG2 = 4,
    parameter logic INV   = 1'b1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          CE,
    input  logic          ADCin,
    output logic          FBout,
    output logic [MSBI:0] DOUT,
    output logic          DVALID
);

    localparam int W     = cic_width(RLOG2);
    localparam int SHIFT = CIC_ORDER * RLOG2 - MSBI - 1;

    localparam logic [MSBI:0] MIDSCALE = {1'b1, {MSBI{1'b0}}};
    localparam logic [1:0] WARM_LAST = 2'(WARMUP_BOUNDARIES - 1);

    logic bit_s;

    sd_sync2 u_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d_i   (ADCin),
        .q_o   (bit_s)
    );

    logic             fb_q;
    logic [W-1:0]     i1_q;
    logic [W-1:0]     i2_q;
    logic [W-1:0]     i3_q;
    logic [W-1:0]     d1_q;
    logic [W-1:0]     d2_q;
    logic [W-1:0]     d3_q;
    logic [RLOG2-1:0] cnt_q;
    logic [1:0]       warm_q;
    logic [1:0]       warm_d;
    phase_e           phase_q;
    phase_e           phase_d;
    logic [MSBI:0]    dout_q;
    logic             dv_q;

    logic             boundary;
    logic             emit;
    logic [W-1:0]     c1;
    logic [W-1:0]     c2;
    logic [W-1:0]     c3;
    logic [MSBI+1:0]  s_full;
    logic [MSBI:0]    sample;

    assign boundary = CE && (&cnt_q);

    // Combs wrap in W bits; the true difference always fits.
    assign c1 = i3_q - d1_q;
    assign c2 = c1 - d2_q;
    assign c3 = c2 - d3_q;

    assign s_full = c3[W-1:SHIFT];
    assign sample = s_full[MSBI+1] ? {(MSBI+1){1'b1}} : s_full[MSBI:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fb_q <= INV;
            i1_q <= '0;
            i2_q <= '0;
            i3_q <= '0;
            cnt_q <= '0;
        end else if (CE) begin
            fb_q <= bit_s ^ INV;
            i1_q <= i1_q + W'(bit_s);
            i2_q <= i2_q + i1_q;
            i3_q <= i3_q + i2_q;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            d1_q <= '0;
            d2_q <= '0;
            d3_q <= '0;
        end else if (boundary) begin
            d1_q <= i3_q;
            d2_q <= c1;
            d3_q <= c2;
        end
    end

    // The first boundaries only prime the comb delays.
    always_comb begin
        phase_d = phase_q;
        warm_d = warm_q;
        emit = 1'b0;
        unique case (phase_q)
            PH_WARMUP: begin
                if (boundary) begin
                    warm_d = warm_q + 1'b1;
                    if (warm_q == WARM_LAST) begin
                        phase_d = PH_RUN;
                        warm_d = '0;
                    end
                end
            end
            PH_RUN: begin
                emit = boundary;
            end
            default: begin
                phase_d = PH_WARMUP;
                warm_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q <= PH_WARMUP;
            warm_q <= '0;
        end else begin
            phase_q <= phase_d;
            warm_q <= warm_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dout_q <= MIDSCALE;
            dv_q <= 1'b0;
        end else begin
            dv_q <= emit;
            if (emit) begin
                dout_q <= sample;
            end
        end
    end

    a_width_ok: assert property (
        @(posedge CLK) (CIC_ORDER * RLOG2 >= MSBI + 1)
    );

    assign FBout = fb_q;
    assign DOUT = dout_q;
    assign DVALID = dv_q;

endmodule
